// File: rtl/traffic_timer.sv
// Interval timer for the traffic-light controller: a prescaled tick counter that raises
// short (ts) and long (tl) timeout levels after runtime-programmable tick counts.
module traffic_timer #(
    parameter int PRESCALE  = 1000,
    parameter int CNT_W     = 8,
    parameter int SHORT_DEF = 5,
    parameter int LONG_DEF  = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_short,
    input  logic [CNT_W-1:0] cfg_long,
    output logic             ts,
    output logic             tl,
    output logic             busy,
    output logic [CNT_W-1:0] elapsed,
    output logic             cfg_err
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_MAX    = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] SHORT_RST = CNT_W'(SHORT_DEF);
    localparam logic [CNT_W-1:0] LONG_RST  = CNT_W'(LONG_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [PS_W-1:0]  presc;
    logic [CNT_W-1:0] act_short;
    logic [CNT_W-1:0] act_long;
    logic [CNT_W-1:0] pend_short;
    logic [CNT_W-1:0] pend_long;

    // One extra bit so elapsed+1 can never wrap before it is compared.
    function automatic logic [CNT_W:0] incr(input logic [CNT_W-1:0] v);
        return {1'b0, v} + {{CNT_W{1'b0}}, 1'b1};
    endfunction

    function automatic logic reached(input logic [CNT_W:0] cnt, input logic [CNT_W-1:0] limit);
        return cnt >= {1'b0, limit};
    endfunction

    logic [CNT_W:0] elapsed_nxt;
    logic           tick;

    always_comb begin
        elapsed_nxt = incr(elapsed);
        tick        = (presc == PS_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            presc      <= '0;
            elapsed    <= '0;
            ts         <= 1'b0;
            tl         <= 1'b0;
            busy       <= 1'b0;
            cfg_err    <= 1'b0;
            act_short  <= SHORT_RST;
            act_long   <= LONG_RST;
            pend_short <= SHORT_RST;
            pend_long  <= LONG_RST;
        end else begin
            cfg_err <= 1'b0;
            if (cfg_we) begin
                if (cfg_short > cfg_long) begin
                    cfg_err <= 1'b1;
                end else begin
                    pend_short <= cfg_short;
                    pend_long  <= cfg_long;
                end
            end

            // A start always wins over a coincident tick; it latches the pending
            // durations as they stood before any same-edge config write.
            if (st) begin
                act_short <= pend_short;
                act_long  <= pend_long;
                presc     <= '0;
                elapsed   <= '0;
                ts        <= (pend_short == '0);
                if (pend_long == '0) begin
                    tl    <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end else begin
                    tl    <= 1'b0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (tick) begin
                            presc   <= '0;
                            elapsed <= elapsed_nxt[CNT_W-1:0];
                            if (reached(elapsed_nxt, act_short)) begin
                                ts <= 1'b1;
                            end
                            if (reached(elapsed_nxt, act_long)) begin
                                tl    <= 1'b1;
                                busy  <= 1'b0;
                                state <= DONE;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule
